// File: rtl/glitch_pkg.sv
// Shared types and defaults for the glitch sequencer: FSM encoding,
// default counter widths and the select code driven out of reset.
`timescale 1ns/1ps
package glitch_pkg;

  localparam int DELAY_W = 32;
  localparam int WIDTH_W = 16;
  localparam int COUNT_W = 8;

  localparam logic [2:0] MUX_SEL_RESET = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    PULSE,
    GAP,
    DONE
  } SeqState;

endpackage

// File: rtl/glitch_sequencer_trig.sv
// Two-flop synchroniser for an asynchronous trigger pin followed by a
// polarity-selectable edge detector producing a registered one-cycle strobe.
`timescale 1ns/1ps
module trig_sync_edge
  import glitch_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_trig,
  input  logic i_rising,
  output logic o_det
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_det;
  logic w_edge;

  assign w_edge = i_rising ? (r_sync2 & ~r_prev) : (~r_sync2 & r_prev);

  // The strobe lands three clocks after the raw pin edge
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_det   <= 1'b0;
    end else begin
      r_sync1 <= i_trig;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_det   <= w_edge;
    end
  end

  assign o_det = r_det;

endmodule

// File: rtl/glitch_sequencer.sv
// Armed, trigger-started glitch pulse sequencer driving the MAX4619 select
// lines between an idle rail and a glitch rail with 10 ns resolution.
`timescale 1ns/1ps
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int DELAY_W = glitch_pkg::DELAY_W,
  parameter int WIDTH_W = glitch_pkg::WIDTH_W,
  parameter int COUNT_W = glitch_pkg::COUNT_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [DELAY_W-1:0] i_cfg_delay,
  input  logic [WIDTH_W-1:0] i_cfg_width,
  input  logic [WIDTH_W-1:0] i_cfg_gap,
  input  logic [COUNT_W-1:0] i_cfg_count,
  input  logic [2:0]         i_cfg_idle_sel,
  input  logic [2:0]         i_cfg_glitch_sel,
  input  logic               i_cfg_edge,
  input  logic               i_arm,
  input  logic               i_abort,
  input  logic               i_trig_in,
  output logic [2:0]         o_mux_sel,
  output logic               o_glitch_active,
  output logic               o_armed,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [DELAY_W-1:0] DELAY_ONE = DELAY_W'(1);
  localparam logic [WIDTH_W-1:0] WIDTH_ONE = WIDTH_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  SeqState r_state;
  SeqState w_nextState;
  logic [2:0] w_muxNext;
  logic w_trigDet;
  logic w_latchCfg;

  logic [DELAY_W-1:0] r_cfgDelay;
  logic [WIDTH_W-1:0] r_cfgWidth;
  logic [WIDTH_W-1:0] r_cfgGap;
  logic [COUNT_W-1:0] r_cfgCount;
  logic [2:0]         r_cfgIdleSel;
  logic [2:0]         r_cfgGlitchSel;
  logic               r_cfgEdge;

  logic [DELAY_W-1:0] r_delayCtr;
  logic [WIDTH_W-1:0] r_widthCtr;
  logic [WIDTH_W-1:0] r_gapCtr;
  logic [COUNT_W-1:0] r_pulseCtr;

  logic [2:0] r_muxSel;
  logic       r_glitchActive;
  logic       r_done;

  trig_sync_edge u_trigSync (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_trig   (i_trig_in),
    .i_rising (r_cfgEdge),
    .o_det    (w_trigDet)
  );

  // Outputs are registered from the next state, so they line up with r_state
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_arm) w_nextState = ARMED;
      ARMED:   if (w_trigDet) w_nextState = (r_cfgDelay == '0) ? PULSE : DELAY;
      DELAY:   if (r_delayCtr <= DELAY_ONE) w_nextState = PULSE;
      PULSE:   if (r_widthCtr <= WIDTH_ONE)
                 w_nextState = (r_pulseCtr <= COUNT_ONE) ? DONE : GAP;
      GAP:     if (r_gapCtr <= WIDTH_ONE) w_nextState = PULSE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (i_abort) w_nextState = IDLE;

    w_latchCfg = (r_state == IDLE) && (w_nextState == ARMED);

    if (w_nextState == PULSE)
      w_muxNext = r_cfgGlitchSel;
    else if (w_nextState == IDLE || r_state == IDLE)
      w_muxNext = i_cfg_idle_sel;
    else
      w_muxNext = r_cfgIdleSel;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_muxSel       <= MUX_SEL_RESET;
      r_glitchActive <= 1'b0;
      r_done         <= 1'b0;
      r_cfgDelay     <= '0;
      r_cfgWidth     <= WIDTH_ONE;
      r_cfgGap       <= WIDTH_ONE;
      r_cfgCount     <= COUNT_ONE;
      r_cfgIdleSel   <= MUX_SEL_RESET;
      r_cfgGlitchSel <= MUX_SEL_RESET;
      r_cfgEdge      <= 1'b1;
      r_delayCtr     <= '0;
      r_widthCtr     <= '0;
      r_gapCtr       <= '0;
      r_pulseCtr     <= '0;
    end else begin
      r_state        <= w_nextState;
      r_muxSel       <= w_muxNext;
      r_glitchActive <= (w_nextState == PULSE);
      r_done         <= (w_nextState == DONE);

      if (w_latchCfg) begin
        r_cfgDelay     <= i_cfg_delay;
        r_cfgWidth     <= (i_cfg_width == '0) ? WIDTH_ONE : i_cfg_width;
        r_cfgGap       <= (i_cfg_gap == '0) ? WIDTH_ONE : i_cfg_gap;
        r_cfgCount     <= (i_cfg_count == '0) ? COUNT_ONE : i_cfg_count;
        r_cfgIdleSel   <= i_cfg_idle_sel;
        r_cfgGlitchSel <= i_cfg_glitch_sel;
        r_cfgEdge      <= i_cfg_edge;
        r_pulseCtr     <= (i_cfg_count == '0) ? COUNT_ONE : i_cfg_count;
      end

      // All counters count down and hold at zero rather than wrapping
      case (r_state)
        ARMED: r_delayCtr <= r_cfgDelay;
        DELAY: if (r_delayCtr != '0) r_delayCtr <= r_delayCtr - DELAY_ONE;
        PULSE: begin
          if (r_widthCtr != '0) r_widthCtr <= r_widthCtr - WIDTH_ONE;
          if (r_widthCtr <= WIDTH_ONE && r_pulseCtr != '0)
            r_pulseCtr <= r_pulseCtr - COUNT_ONE;
        end
        GAP:   if (r_gapCtr != '0) r_gapCtr <= r_gapCtr - WIDTH_ONE;
        default: ;
      endcase

      if (w_nextState == PULSE && r_state != PULSE) r_widthCtr <= r_cfgWidth;
      if (w_nextState == GAP && r_state != GAP) r_gapCtr <= r_cfgGap;
    end
  end

  assign o_mux_sel       = r_muxSel;
  assign o_glitch_active = r_glitchActive;
  assign o_done          = r_done;
  assign o_busy          = (r_state != IDLE);
  assign o_armed         = (r_state == ARMED);

endmodule
